// File: rtl/drv_switch_pkg.sv
// drv_switch_pkg: shared constants, hold-state type and width helper for the switch driver
package drv_switch_pkg;
  localparam int PULLUP = 0;
  localparam int PULLDOWN = 1;
  typedef enum logic [1:0] {IDLE, HELD, REPT} hold_t;
  function automatic int hc_width(input int lng, input int rpt);
    return $clog2(lng + rpt) + 1;
  endfunction
endpackage

// File: rtl/drv_switch_ch.sv
// drv_switch_ch: per-channel synchroniser, debounce, event registers and hold FSM
module drv_switch_ch import drv_switch_pkg::*; #(
  parameter int p_db = 4,
  parameter int p_long = 64,
  parameter int p_rept = 16,
  parameter int p_mode = PULLUP
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sw,
  output logic press,
  output logic click,
  output logic rel,
  output logic lng,
  output logic rep,
  output logic toggle
);
  localparam logic REL_LVL = (p_mode == PULLUP);
  localparam int HW = hc_width(p_long, p_rept);
  logic s1, s2, pr, flip, long_n, rep_n;
  logic [7:0] dc;
  logic [HW-1:0] hc, hc_n, hc_inc;
  hold_t state, state_n;
  assign pr = s2 ^ REL_LVL;
  assign flip = tick && (pr != press) && (dc == 8'(p_db - 1));
  assign hc_inc = hc + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= REL_LVL;
      s2 <= REL_LVL;
      dc <= '0;
      press <= 1'b0;
      click <= 1'b0;
      rel <= 1'b0;
      toggle <= 1'b0;
      lng <= 1'b0;
      rep <= 1'b0;
      hc <= '0;
      state <= IDLE;
    end else begin
      s1 <= sw;
      s2 <= s1;
      dc <= (pr == press || flip) ? 8'd0 : tick ? dc + 8'd1 : dc;
      press <= press ^ flip;
      click <= flip && pr;
      rel <= flip && !pr;
      toggle <= toggle ^ (flip && pr);
      lng <= long_n;
      rep <= rep_n;
      hc <= hc_n;
      state <= state_n;
    end
  end
  // while held, a debounced edge can only be the release
  always_comb begin
    state_n = state;
    hc_n = hc;
    long_n = 1'b0;
    rep_n = 1'b0;
    case (state)
      IDLE: if (flip && pr) begin
        state_n = HELD;
        hc_n = '0;
      end
      HELD, REPT: if (flip) state_n = IDLE;
      else if (tick) begin
        hc_n = hc_inc;
        if (hc_inc == (state == HELD ? HW'(p_long) : HW'(p_rept))) begin
          long_n = (state == HELD);
          rep_n = 1'b1;
          hc_n = '0;
          state_n = REPT;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/drv_switch_ext_w.sv
// drv_switch_ext_w: row switch driver with shared prescaler, per-channel events and click encoder
module drv_switch_ext_w import drv_switch_pkg::*; #(
  parameter int p_width = 4,
  parameter int p_scale = 5,
  parameter int p_db = 4,
  parameter int p_long = 64,
  parameter int p_rept = 16,
  parameter int p_mode = PULLUP,
  localparam int CW = (p_width > 1) ? $clog2(p_width) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [p_width-1:0] i_drv_sw,
  output logic [p_width-1:0] o_press,
  output logic [p_width-1:0] o_click,
  output logic [p_width-1:0] o_release,
  output logic [p_width-1:0] o_long,
  output logic [p_width-1:0] o_repeat,
  output logic [p_width-1:0] o_toggle,
  output logic               o_toggle_common,
  output logic [CW-1:0]      o_code,
  output logic               o_code_valid
);
  logic [p_scale-1:0] pc;
  logic tick;
  assign tick = &pc;
  always_ff @(posedge i_clk) begin
    if (i_rst) pc <= '0;
    else pc <= pc + 1'b1;
  end
  for (genvar i = 0; i < p_width; i++) begin : g_ch
    drv_switch_ch #(.p_db(p_db), .p_long(p_long), .p_rept(p_rept), .p_mode(p_mode)) u_ch (
      .clk(i_clk), .rst(i_rst), .tick(tick), .sw(i_drv_sw[i]),
      .press(o_press[i]), .click(o_click[i]), .rel(o_release[i]),
      .lng(o_long[i]), .rep(o_repeat[i]), .toggle(o_toggle[i])
    );
  end
  assign o_toggle_common = |o_toggle;
  assign o_code_valid = |o_click;
  // scan downwards so the lowest clicking channel is written last
  always_comb begin
    o_code = '0;
    for (int k = p_width - 1; k >= 0; k--) o_code = o_click[k] ? CW'(k) : o_code;
  end
endmodule

// File: tb/tb_drv_switch_ext_w.sv
// tb_drv_switch_ext_w: model-checked and directed bench for the row switch driver
module tb_drv_switch_ext_w;
  import drv_switch_pkg::*;
  localparam int P_SCALE = 2, P_DB = 4, P_LONG = 8, P_REPT = 4;
  localparam int TICKP = 1 << P_SCALE;
  logic clk = 0, rst = 1;
  logic [3:0] sw = 4'hF, pd_sw = 4'h0;
  logic [3:0] o_press, o_click, o_release, o_long, o_repeat, o_toggle;
  logic o_toggle_common, o_code_valid;
  logic [1:0] o_code;
  logic [3:0] pd_press, pd_click, pd_release, pd_long, pd_repeat, pd_toggle;
  logic pd_common, pd_valid;
  logic [1:0] pd_code;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  drv_switch_ext_w #(.p_width(4), .p_scale(P_SCALE), .p_db(P_DB), .p_long(P_LONG), .p_rept(P_REPT), .p_mode(PULLUP)) dut (
    .i_clk(clk), .i_rst(rst), .i_drv_sw(sw), .o_press(o_press), .o_click(o_click),
    .o_release(o_release), .o_long(o_long), .o_repeat(o_repeat), .o_toggle(o_toggle),
    .o_toggle_common(o_toggle_common), .o_code(o_code), .o_code_valid(o_code_valid));

  drv_switch_ext_w #(.p_width(4), .p_scale(P_SCALE), .p_db(P_DB), .p_long(P_LONG), .p_rept(P_REPT), .p_mode(PULLDOWN)) dut_pd (
    .i_clk(clk), .i_rst(rst), .i_drv_sw(pd_sw), .o_press(pd_press), .o_click(pd_click),
    .o_release(pd_release), .o_long(pd_long), .o_repeat(pd_repeat), .o_toggle(pd_toggle),
    .o_toggle_common(pd_common), .o_code(pd_code), .o_code_valid(pd_valid));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // sel: 0 press, 1 click, 2 long, 3 repeat, 4 pulldown press; cyc = -1 on timeout
  task automatic wait_bit(input int sel, input int ch, input int maxc, output int cyc);
    logic [3:0] v;
    cyc = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(posedge clk); #1;
      v = sel == 0 ? o_press : sel == 1 ? o_click : sel == 2 ? o_long : sel == 3 ? o_repeat : pd_press;
      if (v[ch]) begin
        cyc = k;
        break;
      end
    end
  endtask

  // behavioural model: debounce as a run of differing tick samples, hold events from ticks since press
  int n;
  bit d1[4], d2[4], st[4], tg[4], held[4];
  int run[4], ht[4];
  bit m_ok = 0, tick, pr, flip;
  logic [3:0] e_press, e_click, e_rel, e_long, e_rep, e_tog;
  logic [1:0] e_code;
  bit e_valid;
  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1;
      n = 0;
      for (int c = 0; c < 4; c++) begin
        d1[c] = 1; d2[c] = 1; st[c] = 0; tg[c] = 0; held[c] = 0; run[c] = 0; ht[c] = 0;
      end
      {e_press, e_click, e_rel, e_long, e_rep, e_tog} = '0;
    end else begin
      n++;
      tick = (n % TICKP) == 0;
      for (int c = 0; c < 4; c++) begin
        pr = !d2[c];
        d2[c] = d1[c];
        d1[c] = sw[c];
        flip = 0;
        if (pr == st[c]) run[c] = 0;
        else if (tick) begin
          run[c]++;
          if (run[c] == P_DB) begin
            st[c] = pr;
            run[c] = 0;
            flip = 1;
          end
        end
        e_press[c] = st[c];
        e_click[c] = flip && st[c];
        e_rel[c] = flip && !st[c];
        if (e_click[c]) tg[c] = !tg[c];
        e_tog[c] = tg[c];
        e_long[c] = 0;
        e_rep[c] = 0;
        if (e_click[c]) begin
          held[c] = 1;
          ht[c] = 0;
        end else if (e_rel[c]) held[c] = 0;
        else if (held[c] && tick) begin
          ht[c]++;
          e_long[c] = ht[c] == P_LONG;
          e_rep[c] = ht[c] >= P_LONG && (ht[c] - P_LONG) % P_REPT == 0;
        end
      end
    end
    e_valid = |e_click;
    e_code = 0;
    for (int c = 3; c >= 0; c--) if (e_click[c]) e_code = 2'(c);
  end

  always @(posedge clk) begin
    #1;
    if (m_ok) begin
      check("press", o_press, e_press);
      check("click", o_click, e_click);
      check("release", o_release, e_rel);
      check("long", o_long, e_long);
      check("repeat", o_repeat, e_rep);
      check("toggle", o_toggle, e_tog);
      check("toggle_common", o_toggle_common, |e_tog);
      check("code", o_code, e_code);
      check("code_valid", o_code_valid, e_valid);
    end
  end

  bit pd_bad = 0;
  always @(posedge clk) begin
    #1;
    if (m_ok && !rst && pd_sw == 0 && (|{pd_press, pd_click, pd_release, pd_long, pd_repeat, pd_toggle, pd_common, pd_valid}))
      pd_bad = 1;
  end

  task automatic tap(input int ch, input int hold);
    @(negedge clk) sw[ch] = 0;
    repeat (hold) @(negedge clk);
    sw[ch] = 1;
    repeat (25) @(negedge clk);
  endtask

  initial begin
    int c;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    check("reset_press", o_press, 0);
    check("reset_toggle", o_toggle, 0);
    check("reset_code_valid", o_code_valid, 0);
    // bounce shorter than the debounce window
    tap(0, 10);
    check("bounce_press", o_press, 0);
    check("bounce_toggle", o_toggle, 0);
    // clean press
    @(negedge clk) sw[0] = 0;
    wait_bit(0, 0, 40, c);
    check_range("press_latency", c, 15, 18);
    check("click0", o_click, 4'b0001);
    check("toggle0_first", o_toggle[0], 1);
    check("common_first", o_toggle_common, 1);
    @(negedge clk) sw[0] = 1;
    repeat (25) @(negedge clk);
    // two more clicks on ch0
    sw[0] = 0;
    wait_bit(1, 0, 40, c);
    check("toggle0_second", o_toggle[0], 0);
    check("common_second", o_toggle_common, 0);
    @(negedge clk) sw[0] = 1;
    repeat (25) @(negedge clk);
    sw[0] = 0;
    wait_bit(1, 0, 40, c);
    check("toggle0_third", o_toggle[0], 1);
    @(negedge clk) sw[0] = 1;
    repeat (25) @(negedge clk);
    // simultaneous clicks on ch1 and ch3
    sw[1] = 0;
    sw[3] = 0;
    wait_bit(1, 1, 40, c);
    check("simul_click", o_click, 4'b1010);
    check("simul_code", o_code, 1);
    check("simul_valid", o_code_valid, 1);
    @(posedge clk); #1;
    check("simul_valid_drop", o_code_valid, 0);
    @(negedge clk) {sw[1], sw[3]} = 2'b11;
    repeat (25) @(negedge clk);
    // long press and auto-repeat on ch2
    sw[2] = 0;
    wait_bit(1, 2, 40, c);
    check_range("click2_latency", c, 15, 18);
    wait_bit(2, 2, 60, c);
    check("long_delay", c, 32);
    check("repeat_at_long", o_repeat, 4'b0100);
    wait_bit(3, 2, 40, c);
    check("repeat_gap1", c, 16);
    wait_bit(3, 2, 40, c);
    check("repeat_gap2", c, 16);
    // reset while in auto-repeat, button still held
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    check("midrst_press", o_press, 0);
    check("midrst_toggle", o_toggle, 0);
    check("midrst_repeat", o_repeat, 0);
    @(negedge clk) rst = 0;
    wait_bit(1, 2, 40, c);
    check_range("reclick_latency", c, 15, 18);
    @(negedge clk) sw[2] = 1;
    repeat (30) @(negedge clk);
    check("release_quiet", o_press, 0);
    // pulldown build
    check("pd_idle", pd_bad, 0);
    pd_sw[0] = 1;
    wait_bit(4, 0, 40, c);
    check_range("pd_press_latency", c, 15, 18);
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/drv_switch_ext_w.md
Name: drv_switch_ext_w

Overview:
Parametrised successor to the per-row switch driver, for a row of tactile buttons or toggle switches.
- Per channel: synchronises, debounces and classifies each input into press level, click, release, toggle, long-press and auto-repeat events.
- Row level: provides a priority-encoded click index for keypad-style consumers.
- Placement: between the board pins and the control/menu logic; all outputs are synchronous to i_clk.

Parameters:
p_width, 4, number of switch channels (1..32)
p_scale, 5, prescaler exponent; one sample tick every 2^p_scale clocks (p_scale >= 1)
p_db, 4, debounce length in ticks; an input must differ from the stable state for p_db consecutive ticks (1..255)
p_long, 64, hold time in ticks, measured from the debounced press, before the long-press event (>= 1)
p_rept, 16, auto-repeat period in ticks after the long-press event (>= 1)
p_mode, PULLUP, input polarity: PULLUP means raw 0 = pressed; PULLDOWN means raw 1 = pressed

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous, active-high reset
i_drv_sw  input  p_width  raw asynchronous switch pins
o_press  output  p_width  debounced pressed level
o_click  output  p_width  1-cycle pulse on debounced press
o_release  output  p_width  1-cycle pulse on debounced release
o_long  output  p_width  1-cycle pulse when the long-press threshold is reached
o_repeat  output  p_width  1-cycle pulse at the long-press threshold, then every p_rept ticks while held
o_toggle  output  p_width  level that flips on each click
o_toggle_common  output  1  OR of all o_toggle bits
o_code  output  CW  index of the lowest-numbered channel clicking this cycle; CW = max(1, clog2(p_width))
o_code_valid  output  1  1-cycle pulse: at least one o_click bit set this cycle

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst and takes priority over everything else.
- Reset values:
  - all outputs 0, o_code 0;
  - prescaler, debounce and hold counters 0;
  - channel FSMs in IDLE;
  - synchroniser flops preloaded with the released raw level (1 for PULLUP, 0 for PULLDOWN).
- Prescaler:
  - shared p_scale-bit counter, free-running, wraps;
  - tick = 1 for one clock when the counter equals all-ones;
  - the first tick after reset falls on clock 2^p_scale.
- Synchroniser: 2 flops per channel. Then normalise: pr = sync XOR (p_mode==PULLUP), so pr = 1 means pressed.
- Debounce, per channel (stable bit st, counter dc, 8 bits):
  - if pr == st, dc := 0 on every clock;
  - else, on each tick: if dc == p_db-1 then st := pr and dc := 0, else dc := dc+1;
  - any single sample with pr == st restarts the count;
  - latency from a clean pin edge to the o_press change: 2 clocks + between (p_db-1)·2^p_scale+1 and p_db·2^p_scale clocks.
- Events are registered and take effect on the same edge that st changes:
  - o_press = st;
  - o_click pulses in the first cycle o_press is 1;
  - o_release pulses in the first cycle o_press is 0;
  - o_toggle flips on the same edge o_click is set.
- Hold FSM, per channel (hold counter hc, width clog2(p_long+p_rept)+1):
  - IDLE: on st 0->1, hc := 0 and go to HELD.
  - HELD: hc increments on each tick; when hc reaches p_long on a tick, pulse o_long and o_repeat, hc := 0, go to REPT.
  - REPT: hc increments on each tick; when hc reaches p_rept on a tick, pulse o_repeat and set hc := 0.
  - HELD/REPT: on st 1->0, go to IDLE. The o_release pulse is emitted; no o_long/o_repeat is emitted on that edge.
  - A hold that never reaches p_long produces click and release only.
- Encoder:
  - o_code / o_code_valid are combinational from the registered o_click, so they are cycle-aligned with o_click;
  - the lowest index wins on simultaneous clicks;
  - when o_code_valid = 0, o_code = 0.
- Reset mid-operation: a button still held after reset is released must be re-debounced and produces a fresh o_click. The toggle state is lost.
- Counters must never overflow. Widths are derived from the parameters; unused states return to IDLE.

Decomposition:
- Package drv_switch_pkg holds:
  - mode constants PULLUP = 0 and PULLDOWN = 1, replacing the local macros;
  - hold-state enum {IDLE, HELD, REPT};
  - width helper function for the hold counter.
- Sub-module drv_switch_ch contains the per-channel synchroniser, debounce, event registers and hold FSM. Its inputs are clk, rst and the shared tick.
- The top module contains the prescaler, the generate loop over drv_switch_ch, the toggle OR and the priority encoder.

Test Plan:
All scenarios use p_width=4, p_scale=2 (tick every 4 clocks), p_db=4, p_long=8, p_rept=4, PULLUP, unless stated otherwise.
1. Bounce rejection: ch0 pin 1->0 for 10 clocks, then back to 1 -> no o_press/o_click on any channel. Clean 0 held -> o_press[0] rises 15..18 clocks after the pin edge, o_click[0] is a single 1-cycle pulse, o_toggle[0]=1, o_toggle_common=1.
2. Long and repeat: hold ch2 for 80 ticks -> o_long[2] once, 32 clocks after o_click[2]; o_repeat[2] at +32, +48, +64 ... clocks after o_click[2]. On release -> o_release[2] once, no further repeats.
3. Simultaneous clicks: ch1 and ch3 pressed on the same clock -> o_click=4'b1010 in the same cycle, o_code=1, o_code_valid=1 for exactly 1 cycle.
4. Toggle: click ch0 three times -> o_toggle[0] sequence 1,0,1. o_toggle_common tracks the OR across channels.
5. Reset mid-hold: ch2 in REPT, assert i_rst for 1 clock -> all outputs 0 on the next clock. While still held, a new o_click[2] appears 15..18 clocks after reset deasserts (sync preload is the released level).
6. PULLDOWN build: pin 0->1 for ch0 -> o_press[0]=1 after the debounce window; idle pins at 0 produce no events after reset.
